wishbone_idbus_arbiter: RTL and testbench
=========================================

# wishbone_idbus_arbiter

Two-master, one-slave Wishbone B4 classic arbiter. It merges the CVA5 minimal-variant instruction bus (ibus) and data/peripheral bus (dbus) onto the single shared LiteX idbus port. Arbitration is round-robin, and the grant is held for a full bus cycle (cyc envelope). A programmable watchdog aborts a cycle the slave never acknowledges by returning err to the owning master. It sits in the LiteX wrapper between the core's two Wishbone interfaces and the idbus pins.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: slave-response watchdog limit in cycles; 0 disables the watchdog.
- RESET_LAST_GRANT, 1: master treated as last granted at reset (0 = ibus, 1 = dbus), so ibus wins the first tie.

Ports (clock and reset first). Reset is synchronous and active-high; one clock.
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ibus_adr, ibus_dat_w, ibus_sel  in  30, 32, 4  master-I address, write data, byte select.
- ibus_cyc, ibus_stb, ibus_we  in  1 each  master-I cycle, strobe, write enable.
- ibus_cti, ibus_bte  in  3, 2  master-I cycle type and burst type; passed through unchanged.
- ibus_dat_r, ibus_ack, ibus_err  out  32, 1, 1  read data, ack and err returned to master I.
- dbus_*  same directions and widths as ibus_*  master D.
- idbus_adr, idbus_dat_w, idbus_sel, idbus_cyc, idbus_stb, idbus_we, idbus_cti, idbus_bte  out  30, 32, 4, 1, 1, 1, 3, 2  shared slave request.
- idbus_dat_r, idbus_ack, idbus_err  in  32, 1, 1  shared slave response.
- timeout_pulse  out  1  one-cycle pulse when a cycle is aborted by the watchdog.
- timeout_master  out  1  master owning the aborted cycle (0 = I, 1 = D); valid with timeout_pulse and held until the next abort.

## Operation
- State machine states: IDLE, BUSY, ABORT, DRAIN. Registered signals: state, grant (0 = I, 1 = D), last_grant, watchdog count.
- A master requests when cyc and stb are both high.
- IDLE: all idbus outputs are 0.
  - One requester: grant it and go to BUSY.
  - Both requesting: grant the master that is not last_grant.
  - No requester: stay in IDLE.
- BUSY:
  - idbus request signals are a combinational copy of the granted master's signals.
  - idbus_ack, idbus_err and idbus_dat_r are routed to the granted master only.
  - The non-granted master sees ack = err = 0 and dat_r = 0.
  - When the granted master drops cyc: set last_grant to grant and go to IDLE.
- Watchdog:
  - In BUSY, count increments each cycle in which idbus_stb is high and both idbus_ack and idbus_err are low.
  - Count clears on ack, on err, or when stb is low.
  - When count reaches TIMEOUT_CYCLES-1 and no ack/err is present, go to ABORT.
- ABORT (one cycle):
  - idbus_cyc = idbus_stb = 0.
  - Granted master receives err = 1, ack = 0.
  - timeout_pulse = 1 and timeout_master = grant.
  - Next state is DRAIN.
- DRAIN: idbus_cyc = 0; wait for the granted master's cyc to fall, then set last_grant and go to IDLE. A late slave ack arriving in ABORT or DRAIN is ignored.
- Reset (including mid-cycle):
  - state goes to IDLE, grant = 0, last_grant = RESET_LAST_GRANT, count = 0.
  - All outputs (idbus_*, *_ack, *_err, *_dat_r, timeout_pulse, timeout_master) are 0 the cycle after rst is sampled.

## Timing
- Arbitration latency: one cycle. A request first seen in IDLE appears on idbus in the following cycle.
- Response path is combinational: idbus → granted master ack/err/dat_r, no added latency.
- Back-to-back cycles from the same master take one IDLE bubble between cyc envelopes.
- Burst or multi-beat pipelined cycles stay granted for the whole cyc envelope. The other master waits, with no preemption.
- Watchdog count width is $clog2(TIMEOUT_CYCLES+1); it saturates and must not wrap.
- Fairness: when both masters request continuously, grants strictly alternate I, D, I, D across envelopes.
- A new request arriving in the same cycle the current owner drops cyc is evaluated in the following IDLE cycle.

## Structure
- The cva5_types package receives:
  - the arb_state_t enum {IDLE, BUSY, ABORT, DRAIN};
  - the constants WB_MASTER_I = 1'b0 and WB_MASTER_D = 1'b1.
- One sub-module, wishbone_watchdog: the counter with enable, clear and the TIMEOUT_CYCLES parameter, producing an expire flag. It is reusable for the l1_to_wishbone path.
- Steering muxes and the FSM live in the top module; no other hierarchy.

## Test plan
- ibus-only read at adr 0x0000_0100, slave acks after 2 cycles with dat_r 0xDEAD_BEEF:
  - idbus_cyc rises 1 cycle after ibus_cyc;
  - ibus_dat_r = 0xDEAD_BEEF with ibus_ack;
  - dbus_ack stays 0.
- ibus and dbus both request in the same cycle from reset:
  - ibus is granted first and dbus only after ibus_cyc drops plus one IDLE cycle;
  - repeating both requests for 4 envelopes gives the grant order I, D, I, D.
- dbus write of 0x1234_5678 with sel 4'b0011 while ibus asserts a request:
  - idbus_we = 1, idbus_sel = 0011 and idbus_dat_w match dbus;
  - ibus is held off with ibus_ack = 0 until the dbus envelope ends.
- TIMEOUT_CYCLES = 8, slave never acks a dbus read:
  - idbus_stb stays high for 8 cycles, then ABORT: dbus_err = 1 for 1 cycle, timeout_pulse = 1, timeout_master = 1, idbus_cyc = 0;
  - a late idbus_ack during DRAIN is not forwarded.
- rst asserted during BUSY with idbus_cyc = 1:
  - on the next cycle all outputs are 0 and state is IDLE;
  - with both masters requesting after reset release, ibus is granted first.
- TIMEOUT_CYCLES = 0, slave delays ack by 5000 cycles: no abort, timeout_pulse stays 0, and the ack is delivered normally.

Source files
------------

// File: rtl/cva5_types.sv
// Shared types for the CVA5 LiteX Wishbone glue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cva5_types;

  // Arbiter phases: free, owned by a master, watchdog abort, waiting for the owner to drop cyc.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  localparam logic WB_MASTER_I = 1'b0;
  localparam logic WB_MASTER_D = 1'b1;

endpackage

// File: rtl/wishbone_watchdog.sv
// Slave-response watchdog: counts stalled strobe cycles and flags expiry.
// Latency: o_expire is combinational from i_en and the registered count.
// Backpressure: none; i_clr wins over i_en, count saturates instead of wrapping.
// Ports: i_clk, i_rst (sync, active-high), i_en (stalled cycle), i_clr (restart count), o_expire.
module wishbone_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  // A zero limit still needs a one-bit register to keep the port logic legal.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit ENABLED = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] LAST = ENABLED ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || !ENABLED) begin
      r_count <= '0;
    end else if (i_en && (r_count != {CW{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry fires on the stalled cycle that would be the TIMEOUT_CYCLES-th in a row.
  assign o_expire = ENABLED && i_en && (r_count == LAST);

endmodule

// File: rtl/wishbone_idbus_arbiter.sv
// Round-robin two-master (ibus, dbus) to one-slave (idbus) Wishbone B4 classic arbiter.
// Latency: one cycle from request in IDLE to idbus; response path combinational.
// Backpressure: grant held for the whole cyc envelope; loser sees no ack/err until it wins.
// Ports: clk/rst; ibus_* and dbus_* master sides; idbus_* shared slave side;
//        timeout_pulse/timeout_master report watchdog aborts.
module wishbone_idbus_arbiter
  import cva5_types::*;
#(
  parameter int   TIMEOUT_CYCLES   = 1024,
  parameter logic RESET_LAST_GRANT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] ibus_adr,
  input  logic [31:0] ibus_dat_w,
  input  logic [3:0]  ibus_sel,
  input  logic        ibus_cyc,
  input  logic        ibus_stb,
  input  logic        ibus_we,
  input  logic [2:0]  ibus_cti,
  input  logic [1:0]  ibus_bte,
  output logic [31:0] ibus_dat_r,
  output logic        ibus_ack,
  output logic        ibus_err,
  input  logic [29:0] dbus_adr,
  input  logic [31:0] dbus_dat_w,
  input  logic [3:0]  dbus_sel,
  input  logic        dbus_cyc,
  input  logic        dbus_stb,
  input  logic        dbus_we,
  input  logic [2:0]  dbus_cti,
  input  logic [1:0]  dbus_bte,
  output logic [31:0] dbus_dat_r,
  output logic        dbus_ack,
  output logic        dbus_err,
  output logic [29:0] idbus_adr,
  output logic [31:0] idbus_dat_w,
  output logic [3:0]  idbus_sel,
  output logic        idbus_cyc,
  output logic        idbus_stb,
  output logic        idbus_we,
  output logic [2:0]  idbus_cti,
  output logic [1:0]  idbus_bte,
  input  logic [31:0] idbus_dat_r,
  input  logic        idbus_ack,
  input  logic        idbus_err,
  output logic        timeout_pulse,
  output logic        timeout_master
);

  arb_state_t r_state, w_next_state;
  logic       r_grant, w_next_grant;
  logic       r_last_grant, w_next_last_grant;
  logic       r_timeout_master;

  logic w_req_i, w_req_d;
  logic w_own_cyc, w_own_stb;
  logic w_wd_en, w_wd_expire;

  assign w_req_i   = ibus_cyc & ibus_stb;
  assign w_req_d   = dbus_cyc & dbus_stb;
  assign w_own_cyc = (r_grant == WB_MASTER_D) ? dbus_cyc : ibus_cyc;
  assign w_own_stb = (r_grant == WB_MASTER_D) ? dbus_stb : ibus_stb;

  // Only an unanswered strobe in BUSY counts as a stall; anything else restarts the count.
  assign w_wd_en = (r_state == BUSY) && w_own_stb && !idbus_ack && !idbus_err;

  wishbone_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (w_wd_en),
    .i_clr    (!w_wd_en),
    .o_expire (w_wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_grant          <= WB_MASTER_I;
      r_last_grant     <= RESET_LAST_GRANT;
      r_timeout_master <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_grant      <= w_next_grant;
      r_last_grant <= w_next_last_grant;
      // Captured on entry to ABORT so it is already valid alongside timeout_pulse.
      if (r_state == BUSY && w_next_state == ABORT) begin
        r_timeout_master <= r_grant;
      end
    end
  end

  assign timeout_master = r_timeout_master;

  always_comb begin
    w_next_state      = r_state;
    w_next_grant      = r_grant;
    w_next_last_grant = r_last_grant;
    idbus_adr         = '0;
    idbus_dat_w       = '0;
    idbus_sel         = '0;
    idbus_cyc         = 1'b0;
    idbus_stb         = 1'b0;
    idbus_we          = 1'b0;
    idbus_cti         = '0;
    idbus_bte         = '0;
    ibus_dat_r        = '0;
    ibus_ack          = 1'b0;
    ibus_err          = 1'b0;
    dbus_dat_r        = '0;
    dbus_ack          = 1'b0;
    dbus_err          = 1'b0;
    timeout_pulse     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_req_i && w_req_d) begin
          w_next_grant = ~r_last_grant;
          w_next_state = BUSY;
        end else if (w_req_i) begin
          w_next_grant = WB_MASTER_I;
          w_next_state = BUSY;
        end else if (w_req_d) begin
          w_next_grant = WB_MASTER_D;
          w_next_state = BUSY;
        end
      end

      BUSY: begin
        if (r_grant == WB_MASTER_D) begin
          idbus_adr   = dbus_adr;
          idbus_dat_w = dbus_dat_w;
          idbus_sel   = dbus_sel;
          idbus_cyc   = dbus_cyc;
          idbus_stb   = dbus_stb;
          idbus_we    = dbus_we;
          idbus_cti   = dbus_cti;
          idbus_bte   = dbus_bte;
          dbus_dat_r  = idbus_dat_r;
          dbus_ack    = idbus_ack;
          dbus_err    = idbus_err;
        end else begin
          idbus_adr   = ibus_adr;
          idbus_dat_w = ibus_dat_w;
          idbus_sel   = ibus_sel;
          idbus_cyc   = ibus_cyc;
          idbus_stb   = ibus_stb;
          idbus_we    = ibus_we;
          idbus_cti   = ibus_cti;
          idbus_bte   = ibus_bte;
          ibus_dat_r  = idbus_dat_r;
          ibus_ack    = idbus_ack;
          ibus_err    = idbus_err;
        end
        // Owner releasing the bus takes priority over a coincident watchdog expiry.
        if (!w_own_cyc) begin
          w_next_last_grant = r_grant;
          w_next_state      = IDLE;
        end else if (w_wd_expire) begin
          w_next_state = ABORT;
        end
      end

      ABORT: begin
        if (r_grant == WB_MASTER_D) begin
          dbus_err = 1'b1;
        end else begin
          ibus_err = 1'b1;
        end
        timeout_pulse = 1'b1;
        w_next_state  = DRAIN;
      end

      DRAIN: begin
        // Slave is disconnected here, so a late ack/err is simply dropped.
        if (!w_own_cyc) begin
          w_next_last_grant = r_grant;
          w_next_state      = IDLE;
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wishbone_idbus_arbiter.sv
// Bench for wishbone_idbus_arbiter: two instances (watchdog 8 and disabled) share all inputs.
// A transaction-level model predicts every output each cycle; directed steps add literal checks.
module tb_wishbone_idbus_arbiter;

  typedef struct packed {
    logic [29:0] adr;
    logic [31:0] dw;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] idr;
    logic        ia;
    logic        ie;
    logic [31:0] ddr;
    logic        da;
    logic        de;
    logic        tp;
    logic        tm;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [29:0] ibus_adr = '0, dbus_adr = '0;
  logic [31:0] ibus_dat_w = '0, dbus_dat_w = '0;
  logic [3:0]  ibus_sel = '0, dbus_sel = '0;
  logic        ibus_cyc = 1'b0, ibus_stb = 1'b0, ibus_we = 1'b0;
  logic        dbus_cyc = 1'b0, dbus_stb = 1'b0, dbus_we = 1'b0;
  logic [2:0]  ibus_cti = '0, dbus_cti = '0;
  logic [1:0]  ibus_bte = 2'b01, dbus_bte = 2'b10;
  logic [31:0] idbus_dat_r = '0;
  logic        idbus_ack = 1'b0, idbus_err = 1'b0;

  obs_t act [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int TO = (g == 0) ? 8 : 0;
    logic [29:0] o_adr;
    logic [31:0] o_dw, o_idr, o_ddr;
    logic [3:0]  o_sel;
    logic        o_cyc, o_stb, o_we, o_ia, o_ie, o_da, o_de, o_tp, o_tm;
    logic [2:0]  o_cti;
    logic [1:0]  o_bte;

    wishbone_idbus_arbiter #(
      .TIMEOUT_CYCLES   (TO),
      .RESET_LAST_GRANT (1'b1)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .ibus_adr       (ibus_adr),
      .ibus_dat_w     (ibus_dat_w),
      .ibus_sel       (ibus_sel),
      .ibus_cyc       (ibus_cyc),
      .ibus_stb       (ibus_stb),
      .ibus_we        (ibus_we),
      .ibus_cti       (ibus_cti),
      .ibus_bte       (ibus_bte),
      .ibus_dat_r     (o_idr),
      .ibus_ack       (o_ia),
      .ibus_err       (o_ie),
      .dbus_adr       (dbus_adr),
      .dbus_dat_w     (dbus_dat_w),
      .dbus_sel       (dbus_sel),
      .dbus_cyc       (dbus_cyc),
      .dbus_stb       (dbus_stb),
      .dbus_we        (dbus_we),
      .dbus_cti       (dbus_cti),
      .dbus_bte       (dbus_bte),
      .dbus_dat_r     (o_ddr),
      .dbus_ack       (o_da),
      .dbus_err       (o_de),
      .idbus_adr      (o_adr),
      .idbus_dat_w    (o_dw),
      .idbus_sel      (o_sel),
      .idbus_cyc      (o_cyc),
      .idbus_stb      (o_stb),
      .idbus_we       (o_we),
      .idbus_cti      (o_cti),
      .idbus_bte      (o_bte),
      .idbus_dat_r    (idbus_dat_r),
      .idbus_ack      (idbus_ack),
      .idbus_err      (idbus_err),
      .timeout_pulse  (o_tp),
      .timeout_master (o_tm)
    );

    assign act[g] = {o_adr, o_dw, o_sel, o_cyc, o_stb, o_we, o_cti, o_bte,
                     o_idr, o_ia, o_ie, o_ddr, o_da, o_de, o_tp, o_tm};
  end

  int n_chk = 0;
  int n_err = 0;
  int n_tp [2] = '{0, 0};

  // ---------------- transaction-level model ----------------
  // owner: -1 bus free, 0 ibus, 1 dbus. phase: 0 transferring, 1 abort cycle, 2 waiting for release.
  // stall: consecutive owner strobes the slave left unanswered.
  int   tmo     [2] = '{8, 0};
  int   m_owner [2];
  int   m_phase [2];
  int   m_stall [2];
  int   m_last  [2];
  logic m_tm    [2];
  bit   m_init = 1'b0;

  function automatic obs_t expect_obs(int k);
    obs_t e = '0;
    if (m_owner[k] >= 0 && m_phase[k] == 0) begin
      if (m_owner[k] == 0) begin
        e.adr = ibus_adr; e.dw = ibus_dat_w; e.sel = ibus_sel; e.cyc = ibus_cyc;
        e.stb = ibus_stb; e.we = ibus_we; e.cti = ibus_cti; e.bte = ibus_bte;
        e.idr = idbus_dat_r; e.ia = idbus_ack; e.ie = idbus_err;
      end else begin
        e.adr = dbus_adr; e.dw = dbus_dat_w; e.sel = dbus_sel; e.cyc = dbus_cyc;
        e.stb = dbus_stb; e.we = dbus_we; e.cti = dbus_cti; e.bte = dbus_bte;
        e.ddr = idbus_dat_r; e.da = idbus_ack; e.de = idbus_err;
      end
    end else if (m_owner[k] >= 0 && m_phase[k] == 1) begin
      if (m_owner[k] == 0) e.ie = 1'b1;
      else                 e.de = 1'b1;
      e.tp = 1'b1;
    end
    e.tm = m_tm[k];
    return e;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic oc, os;
      oc = (m_owner[k] == 1) ? dbus_cyc : ibus_cyc;
      os = (m_owner[k] == 1) ? dbus_stb : ibus_stb;
      if (rst) begin
        m_owner[k] = -1; m_phase[k] = 0; m_stall[k] = 0; m_last[k] = 1; m_tm[k] = 1'b0;
      end else if (m_owner[k] < 0) begin
        m_stall[k] = 0;
        m_phase[k] = 0;
        if ((ibus_cyc && ibus_stb) && (dbus_cyc && dbus_stb)) m_owner[k] = 1 - m_last[k];
        else if (ibus_cyc && ibus_stb)                        m_owner[k] = 0;
        else if (dbus_cyc && dbus_stb)                        m_owner[k] = 1;
      end else if (m_phase[k] == 0) begin
        if (!oc) begin
          m_last[k] = m_owner[k]; m_owner[k] = -1;
        end else if (os && !idbus_ack && !idbus_err) begin
          if (tmo[k] != 0 && m_stall[k] + 1 == tmo[k]) begin
            m_phase[k] = 1; m_tm[k] = m_owner[k][0]; m_stall[k] = 0;
          end else begin
            m_stall[k]++;
          end
        end else begin
          m_stall[k] = 0;
        end
      end else if (m_phase[k] == 1) begin
        m_phase[k] = 2;
      end else if (!oc) begin
        m_last[k] = m_owner[k]; m_owner[k] = -1; m_phase[k] = 0;
      end
    end
    if (rst) m_init = 1'b1;
  end

  // Single compare process: every cycle after the first reset edge, both instances vs the model.
  always @(negedge clk) begin
    if (m_init) begin
      for (int k = 0; k < 2; k++) begin
        obs_t e;
        e = expect_obs(k);
        n_chk++;
        if (act[k] !== e) begin
          n_err++;
          $display("FAIL model_dut%0d t=%0t got=%h want=%h", k, $time, act[k], e);
        end
        if (act[k].tp === 1'b1) n_tp[k]++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit m, input logic c, input logic s, input logic w,
                     input logic [29:0] a, input logic [31:0] d, input logic [3:0] sl,
                     input logic [2:0] ct);
    if (m) begin
      dbus_cyc = c; dbus_stb = s; dbus_we = w; dbus_adr = a; dbus_dat_w = d; dbus_sel = sl; dbus_cti = ct;
    end else begin
      ibus_cyc = c; ibus_stb = s; ibus_we = w; ibus_adr = a; ibus_dat_w = d; ibus_sel = sl; ibus_cti = ct;
    end
  endtask

  initial begin
    // Reset, then reset-state outputs.
    tick();
    tick();
    rst = 1'b0;
    // Both masters request in the very first free cycle.
    drv(0, 1, 1, 0, 30'h10, 32'h1111_0000, 4'hF, 3'b010);
    drv(1, 1, 1, 0, 30'h20, 32'h2222_0000, 4'hC, 3'b111);
    @(negedge clk);
    chk("rst_tm", act[0].tm, 0);
    chk("rst_ibus_ack", act[0].ia, 0);

    // Fairness: I, D, I, D with an idle bubble before each envelope.
    for (int e = 0; e < 4; e++) begin
      bit own;
      own = e[0];
      if (e > 0) @(negedge clk);
      chk("rr_idle_cyc", act[0].cyc, 0);
      tick();
      idbus_ack = 1'b1;
      idbus_dat_r = 32'hA000_0000 + e;
      @(negedge clk);
      chk("rr_grant_adr", act[0].adr, own ? 64'h20 : 64'h10);
      chk("rr_owner_ack", own ? act[0].da : act[0].ia, 1);
      chk("rr_other_ack", own ? act[0].ia : act[0].da, 0);
      tick();
      idbus_ack = 1'b0;
      drv(own, 0, 0, 0, own ? 30'h20 : 30'h10, 32'h0, 4'h0, 3'b000);
      if (e == 3) drv(0, 0, 0, 0, 30'h10, 32'h0, 4'h0, 3'b000);
      tick();
      if (e < 3) drv(own, 1, 1, 0, own ? 30'h20 : 30'h10,
                     own ? 32'h2222_0000 : 32'h1111_0000, own ? 4'hC : 4'hF,
                     own ? 3'b111 : 3'b010);
    end

    // ibus-only read, slave answers on the third owned cycle.
    drv(0, 1, 1, 0, 30'h100, 32'h0, 4'hF, 3'b000);
    @(negedge clk);
    chk("rd_idbus_cyc_latency", act[0].cyc, 0);
    tick();
    @(negedge clk);
    chk("rd_idbus_cyc", act[0].cyc, 1);
    chk("rd_idbus_adr", act[0].adr, 64'h100);
    tick();
    tick();
    idbus_ack = 1'b1;
    idbus_dat_r = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd_ibus_ack", act[0].ia, 1);
    chk("rd_ibus_dat_r", act[0].idr, 64'hDEAD_BEEF);
    chk("rd_dbus_ack", act[0].da, 0);
    tick();
    idbus_ack = 1'b0;
    drv(0, 0, 0, 0, 30'h0, 32'h0, 4'h0, 3'b000);
    tick();

    // dbus write while ibus waits.
    drv(1, 1, 1, 1, 30'h55, 32'h1234_5678, 4'b0011, 3'b000);
    tick();
    drv(0, 1, 1, 0, 30'h77, 32'h0, 4'hF, 3'b000);
    @(negedge clk);
    chk("wr_idbus_we", act[0].we, 1);
    chk("wr_idbus_sel", act[0].sel, 4'b0011);
    chk("wr_idbus_dat_w", act[0].dw, 64'h1234_5678);
    tick();
    @(negedge clk);
    chk("wr_ibus_held", act[0].ia, 0);
    tick();
    idbus_ack = 1'b1;
    @(negedge clk);
    chk("wr_dbus_ack", act[0].da, 1);
    chk("wr_ibus_no_ack", act[0].ia, 0);
    tick();
    idbus_ack = 1'b0;
    drv(1, 0, 0, 0, 30'h0, 32'h0, 4'h0, 3'b000);
    tick();
    @(negedge clk);
    chk("wr_bubble_cyc", act[0].cyc, 0);
    tick();
    idbus_ack = 1'b1;
    @(negedge clk);
    chk("wr_then_ibus_adr", act[0].adr, 64'h77);
    tick();
    idbus_ack = 1'b0;
    drv(0, 0, 0, 0, 30'h0, 32'h0, 4'h0, 3'b000);
    tick();

    // Watchdog abort on a dbus read that never completes (instance 0, limit 8).
    drv(1, 1, 1, 0, 30'h99, 32'h0, 4'hF, 3'b000);
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("wd_stb_high", act[0].stb, 1);
      tick();
    end
    @(negedge clk);
    chk("wd_dbus_err", act[0].de, 1);
    chk("wd_pulse", act[0].tp, 1);
    chk("wd_master", act[0].tm, 1);
    chk("wd_idbus_cyc", act[0].cyc, 0);
    tick();
    idbus_ack = 1'b1;
    idbus_dat_r = 32'h0000_0BAD;
    @(negedge clk);
    chk("wd_late_ack_dropped", act[0].da, 0);
    chk("wd_pulse_one_cycle", act[0].tp, 0);
    chk("wd_master_held", act[0].tm, 1);
    tick();
    idbus_ack = 1'b0;
    drv(1, 0, 0, 0, 30'h0, 32'h0, 4'h0, 3'b000);
    tick();

    // Reset in the middle of an ibus envelope, dbus also requesting.
    drv(0, 1, 1, 0, 30'h11, 32'h0, 4'hF, 3'b000);
    tick();
    rst = 1'b1;
    drv(1, 1, 1, 0, 30'h22, 32'h0, 4'hF, 3'b000);
    @(negedge clk);
    chk("mrst_busy_cyc", act[0].cyc, 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_idbus_cyc", act[0].cyc, 0);
    chk("mrst_idbus_adr", act[0].adr, 0);
    chk("mrst_tm_cleared", act[0].tm, 0);
    tick();
    idbus_ack = 1'b1;
    @(negedge clk);
    chk("mrst_ibus_first", act[0].adr, 64'h11);
    tick();
    idbus_ack = 1'b0;
    drv(0, 0, 0, 0, 30'h0, 32'h0, 4'h0, 3'b000);
    tick();
    tick();
    idbus_ack = 1'b1;
    @(negedge clk);
    chk("mrst_dbus_second", act[0].adr, 64'h22);
    tick();
    idbus_ack = 1'b0;
    drv(1, 0, 0, 0, 30'h0, 32'h0, 4'h0, 3'b000);
    tick();

    // Watchdog disabled (instance 1): a 5000-cycle slave delay completes normally.
    drv(0, 1, 1, 0, 30'h200, 32'h0, 4'hF, 3'b000);
    tick();
    repeat (5000) tick();
    idbus_ack = 1'b1;
    idbus_dat_r = 32'hC0FF_EE01;
    @(negedge clk);
    chk("slow_ack_delivered", act[1].ia, 1);
    chk("slow_dat_r", act[1].idr, 64'hC0FF_EE01);
    chk("slow_aborted_inst_no_ack", act[0].ia, 0);
    tick();
    idbus_ack = 1'b0;
    drv(0, 0, 0, 0, 30'h0, 32'h0, 4'h0, 3'b000);
    tick();
    tick();
    @(negedge clk);
    chk("no_timeout_when_disabled", n_tp[1], 0);
    chk("timeouts_with_limit_8", n_tp[0], 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
